mac_operand_feeder: RTL and testbench

- Producer end of the MAC operand interface. Accepts a byte stream of signed 8-bit samples interleaved as a0, b0, a1, b1, ..., pairs them, and buffers the pairs in a small FIFO.
- Presents each pair as a, b with valid/ready toward the MAC.
- Tags pairs with frame markers (first/last). A downstream MAC can use these to clear and dump its accumulator every FRAME_LEN products.

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_operand_feeder_if.sv | 33 +++
 rtl/mac_pair_fifo.sv | 61 ++++++
 rtl/mac_operand_feeder.sv | 97 +++++++++
 tb/tb_mac_operand_feeder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types for the MAC operand path.
//   MAC_DATA_W    : operand width
//   mac_operand_t : signed operand
//   mac_pair_t    : {a, b, first, last} entry carried through the pair FIFO
//   phase_e       : pairing phase (PH_A expects an a sample, PH_B a b sample)
package mac_pkg;
  localparam int MAC_DATA_W = 8;

  typedef logic signed [MAC_DATA_W-1:0] mac_operand_t;

  typedef struct packed {
    mac_operand_t a;
    mac_operand_t b;
    logic         first;
    logic         last;
  } mac_pair_t;

  typedef enum logic { PH_A = 1'b0, PH_B = 1'b1 } phase_e;
endpackage

// File: rtl/mac_operand_feeder_if.sv
// Bus bundle of the operand feeder.
//   in_data/in_valid/in_ready : interleaved a,b sample stream into the feeder
//   a/b/out_valid/out_ready   : paired operands toward the MAC
//   out_first/out_last        : frame markers of the head pair
//   level                     : pair FIFO occupancy
// slave = the feeder, master = its environment (sample source + MAC).
interface mac_operand_feeder_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_first;
  logic                     out_last;
  logic [LW-1:0]            level;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, a, b, out_valid, out_first, out_last, level
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, a, b, out_valid, out_first, out_last, level
  );
endinterface

// File: rtl/mac_pair_fifo.sv
// Circular FIFO of mac_pair_t entries.
//   push/wdata : write an entry (ignored when full)
//   pop/rdata  : rdata is the head entry, zero while empty; pop ignored when empty
//   flush      : synchronous clear, wins over push/pop in the same cycle
//   level/full/empty : occupancy status
module mac_pair_fifo
  import mac_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  mac_pair_t                wdata,
  output mac_pair_t                rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  mac_pair_t     r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_count;
  logic          w_push, w_pop;

  assign full   = (r_count == LW'(DEPTH));
  assign empty  = (r_count == '0);
  assign level  = r_count;
  assign w_push = push & ~full  & ~flush;
  assign w_pop  = pop  & ~empty & ~flush;
  assign rdata  = empty ? '0 : r_mem[r_rptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/mac_operand_feeder.sv
// Producer end of the MAC operand interface.
// Pairs an interleaved a0,b0,a1,b1,... sample stream, tags each pair with
// frame markers (first/last every FRAME_LEN pairs) and buffers the pairs.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   flush : synchronous clear of FIFO, pairing phase and frame index
//   bus   : sample input stream and operand output stream (slave modport)
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int DATA_W    = MAC_DATA_W,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  mac_operand_feeder_if.slave bus
);
  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

  phase_e        r_phase, w_phase_nxt;
  mac_operand_t  r_hold;
  logic [IW-1:0] r_idx;
  logic          w_in_ready, w_push, w_pop, w_full, w_empty;
  mac_pair_t     w_wdata, w_rdata;
  logic [LW-1:0] w_level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_phase <= PH_A;
    else if (flush) r_phase <= PH_A;
    else            r_phase <= w_phase_nxt;
  end

  // In PH_B the b sample is only taken when the FIFO has room; no bypass
  // through a same-cycle pop.
  always_comb begin
    w_phase_nxt = r_phase;
    w_in_ready  = 1'b1;
    w_push      = 1'b0;
    case (r_phase)
      PH_A: begin
        if (bus.in_valid) w_phase_nxt = PH_B;
      end
      PH_B: begin
        w_in_ready = ~w_full;
        if (bus.in_valid && !w_full) begin
          w_phase_nxt = PH_A;
          w_push      = ~flush;
        end
      end
      default: w_phase_nxt = PH_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold <= '0;
      r_idx  <= '0;
    end else if (flush) begin
      r_hold <= '0;
      r_idx  <= '0;
    end else begin
      if (r_phase == PH_A && bus.in_valid) r_hold <= bus.in_data;
      if (w_push) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  assign w_wdata = '{a:     r_hold,
                     b:     bus.in_data,
                     first: (r_idx == '0),
                     last:  (r_idx == LAST_IDX)};
  assign w_pop   = ~w_empty & bus.out_ready;

  mac_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (flush),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .level (w_level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.a         = w_rdata.a;
  assign bus.b         = w_rdata.b;
  assign bus.out_first = w_rdata.first;
  assign bus.out_last  = w_rdata.last;
  assign bus.out_valid = ~w_empty;
  assign bus.level     = w_level;
endmodule

// File: tb/tb_mac_operand_feeder.sv
module tb_mac_operand_feeder;
  import mac_pkg::*;

  localparam int DEPTH = 4;
  localparam int FL    = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  mac_operand_feeder_if #(.DATA_W(8), .DEPTH(DEPTH)) bus ();

  mac_operand_feeder #(.DATA_W(8), .DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] oa, ob;
  assign oa = bus.a;
  assign ob = bus.b;

  typedef struct {
    logic [7:0] ai;
    logic [7:0] bi;
    logic       f;
    logic       l;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       f;
    logic       l;
  } pair_t;

  vec_t  tbl [7];
  pair_t q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    logic [7:0] hold;
    int nsamp, npairs;
    bit in_x, out_x, exp_rdy, fl;
    logic [7:0] din;
    logic [3:0] fexp, lexp;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // ---- reset then single pair ----
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_a", oa, 0);
    chk("rst_b", ob, 0);
    chk("rst_first", bus.out_first, 0);
    chk("rst_last", bus.out_last, 0);
    reset = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    send(8'h05);
    chk("single_after_a", bus.out_valid, 0);
    send(8'hFD);
    chk("single_valid", bus.out_valid, 1);
    chk("single_a", oa, 8'h05);
    chk("single_b", ob, 8'hFD);
    chk("single_first", bus.out_first, 1);
    chk("single_level", bus.level, 1);
    step();
    chk("single_drained_valid", bus.out_valid, 0);
    chk("single_drained_level", bus.level, 0);

    // ---- backpressure / full ----
    do_flush();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'h01);
      send(8'h02);
    end
    chk("full_level", bus.level, 4);
    chk("full_ready_pha", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    step();
    chk("full_level_after_a", bus.level, 4);
    bus.in_data = 8'h02;
    #1;
    chk("full_stall_b", bus.in_ready, 0);
    step();
    chk("full_still_stalled", bus.in_ready, 0);
    chk("full_level_stalled", bus.level, 4);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("full_level_after_pop", bus.level, 3);
    chk("full_ready_after_pop", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    chk("full_level_refill", bus.level, 4);
    // remaining pairs 1..4 of a frame of 3: indices 1,2,0,1
    fexp = 4'b0100;
    lexp = 4'b0010;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("full_drain_a", oa, 8'h01);
      chk("full_drain_b", ob, 8'h02);
      chk("full_drain_first", bus.out_first, fexp[k]);
      chk("full_drain_last", bus.out_last, lexp[k]);
      step();
    end
    chk("full_drained", bus.out_valid, 0);

    // ---- frame wrap + signed extremes, continuous streaming ----
    tbl[0] = '{8'h80, 8'h7F, 1'b1, 1'b0};
    tbl[1] = '{8'hFF, 8'h80, 1'b0, 1'b0};
    tbl[2] = '{8'h11, 8'h22, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 8'h01, 1'b1, 1'b0};
    tbl[4] = '{8'h7F, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{8'h33, 8'hCC, 1'b0, 1'b1};
    tbl[6] = '{8'hA5, 8'h5A, 1'b1, 1'b0};
    do_flush();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = tbl[i].ai;
      step();
      chk("tbl_gap_valid", bus.out_valid, 0);
      bus.in_data = tbl[i].bi;
      step();
      chk("tbl_valid", bus.out_valid, 1);
      chk("tbl_a", oa, tbl[i].ai);
      chk("tbl_b", ob, tbl[i].bi);
      chk("tbl_first", bus.out_first, tbl[i].f);
      chk("tbl_last", bus.out_last, tbl[i].l);
      chk("tbl_level", bus.level, 1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("tbl_drained", bus.out_valid, 0);

    // ---- flush mid-pair ----
    do_flush();
    send(8'h10);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h20;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_level", bus.level, 0);
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_ready", bus.in_ready, 1);
    send(8'h30);
    send(8'h40);
    chk("flush_pair_valid", bus.out_valid, 1);
    chk("flush_pair_a", oa, 8'h30);
    chk("flush_pair_b", ob, 8'h40);
    chk("flush_pair_first", bus.out_first, 1);
    step();

    // ---- async reset mid-stream ----
    do_flush();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'(i));
      send(8'(i + 8'h40));
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("arst_pre_level", bus.level, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_level", bus.level, 0);
    chk("arst_a", oa, 0);
    step();
    reset = 1'b1;
    send(8'h55);
    send(8'h66);
    chk("arst_pair_valid", bus.out_valid, 1);
    chk("arst_pair_a", oa, 8'h55);
    chk("arst_pair_first", bus.out_first, 1);
    bus.out_ready = 1'b1;
    step();

    // ---- randomized against a pair/queue model ----
    do_flush();
    q.delete();
    nsamp  = 0;
    npairs = 0;
    hold   = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      din           = 8'($urandom);
      bus.in_data   = din;
      bus.out_ready = 1'($urandom_range(0, 1));
      fl            = ($urandom_range(0, 63) == 0);
      flush         = fl;
      #1;
      exp_rdy = (nsamp % 2 == 0) || (q.size() < DEPTH);
      chk("rnd_in_ready", bus.in_ready, exp_rdy);
      chk("rnd_level", bus.level, q.size());
      chk("rnd_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rnd_a", oa, q[0].a);
        chk("rnd_b", ob, q[0].b);
        chk("rnd_first", bus.out_first, q[0].f);
        chk("rnd_last", bus.out_last, q[0].l);
      end else begin
        chk("rnd_empty_a", oa, 0);
      end
      in_x  = bus.in_valid && exp_rdy;
      out_x = (q.size() != 0) && bus.out_ready;
      step();
      if (fl) begin
        q.delete();
        nsamp  = 0;
        npairs = 0;
        hold   = '0;
      end else begin
        if (out_x) void'(q.pop_front());
        if (in_x) begin
          if (nsamp % 2 == 0) hold = din;
          else begin
            q.push_back('{hold, din, (npairs % FL) == 0, (npairs % FL) == FL - 1});
            npairs++;
          end
          nsamp++;
        end
      end
    end
    flush        = 1'b0;
    bus.in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
